mema_skew_pingpong: RTL

MEMA_SKEW_PINGPONG -- requirements
Module: mema_skew_pingpong

---
 rtl/mema_skew_pingpong.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mema_skew_pingpong.sv
// Ping-pong A-tile buffer feeding a systolic array with a diagonal skew.
// One bank loads by rows while the other streams, optionally transposed.
module mema_skew_pingpong #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             wr_en,
    input  logic [$clog2(DIM)-1:0]           wr_row,
    input  logic [DIM-1:0][BITS_AB-1:0]      wr_data,
    input  logic                             wr_commit,
    input  logic                             wr_transpose,
    output logic                             wr_ready,
    output logic [DIM-1:0][BITS_AB-1:0]      Aout,
    output logic                             a_valid,
    output logic                             tile_done,
    output logic                             overflow,
    output logic                             busy
);

    localparam int KW = $clog2(2*DIM-1);
    localparam logic [KW-1:0] KLAST = KW'(2*DIM-2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [1:0]                  full_q, full_d;
    logic [1:0]                  mode_q, mode_d;
    logic                        ovf_q, ovf_d;
    logic                        a_valid_q, a_valid_d;
    logic                        done_q, done_d;
    logic [DIM-1:0][BITS_AB-1:0] aout_q, aout_d;
    logic [DIM-1:0][BITS_AB-1:0] lane;
    logic                        wr_fire, commit_fire, last_step;

    logic [BITS_AB-1:0] bank_q [2][DIM][DIM];

    assign wr_ready    = !full_q[wr_ptr_q];
    assign wr_fire     = wr_en & wr_ready;
    assign commit_fire = wr_commit & wr_ready;

    assign Aout      = aout_q;
    assign a_valid   = a_valid_q;
    assign tile_done = done_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == STREAM);

    // Tile storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < DIM; c++) begin
                bank_q[wr_ptr_q][wr_row][c] <= wr_data[c];
            end
        end
    end

    // Lane i at step k carries element r = k - i of its row/column.
    always_comb begin
        lane = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int r = 0; r < DIM; r++) begin
                if (k_q == KW'(i + r)) begin
                    lane[i] = mode_q[rd_ptr_q] ? bank_q[rd_ptr_q][r][i]
                                               : bank_q[rd_ptr_q][i][r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            full_q    <= '0;
            mode_q    <= '0;
            ovf_q     <= 1'b0;
            a_valid_q <= 1'b0;
            done_q    <= 1'b0;
            aout_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            full_q    <= full_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            a_valid_q <= a_valid_d;
            done_q    <= done_d;
            aout_q    <= aout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && full_q[rd_ptr_q]) begin
                    state_d = STREAM;
                    k_d     = '0;
                end
            end
            STREAM: begin
                if (en) begin
                    if (k_q == KLAST) begin
                        last_step = 1'b1;
                        k_d       = '0;
                        // Zero-bubble chaining only if the other tile is already full.
                        state_d   = full_q[~rd_ptr_q] ? STREAM : IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aout_d    = aout_q;
        a_valid_d = 1'b0;
        done_d    = 1'b0;
        full_d    = full_q;
        mode_d    = mode_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q | ((wr_en | wr_commit) & ~wr_ready);
        if (state_q == STREAM && en) begin
            aout_d    = lane;
            a_valid_d = 1'b1;
        end
        if (last_step) begin
            done_d           = 1'b1;
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (commit_fire) begin
            full_d[wr_ptr_q] = 1'b1;
            mode_d[wr_ptr_q] = wr_transpose;
            wr_ptr_d         = ~wr_ptr_q;
        end
    end

endmodule
